// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: FSM encoding and
// default widths / HALT encoding used by the top and its sub-module.
package fetch_pkg;

    localparam int              ADDR_W_DEF     = 8;
    localparam int              INSTR_W_DEF    = 16;
    localparam logic [15:0]     HALT_INSTR_DEF = 16'hF000;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_HALTED = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/fetch_skid_buf.sv
// Two-entry synchronous FIFO of {pc, instr} sitting between the BRAM capture
// point and decode. Flush beats push; push and pop may happen together.
module fetch_skid_buf #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 16
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_push,
    input  logic [ADDR_W-1:0]  i_push_pc,
    input  logic [INSTR_W-1:0] i_push_instr,
    input  logic               i_pop,
    input  logic               i_flush,
    output logic [1:0]         o_count,
    output logic [ADDR_W-1:0]  o_head_pc,
    output logic [INSTR_W-1:0] o_head_instr
);

    logic [ADDR_W-1:0]  pc_q    [2];
    logic [ADDR_W-1:0]  pc_d    [2];
    logic [INSTR_W-1:0] instr_q [2];
    logic [INSTR_W-1:0] instr_d [2];
    logic               wr_ptr_q, wr_ptr_d;
    logic               rd_ptr_q, rd_ptr_d;
    logic [1:0]         count_q, count_d;
    logic               do_push, do_pop;

    // Pointer/occupancy update; a full buffer only accepts a push when it pops too.
    always_comb begin
        do_pop   = i_pop && (count_q != 2'd0) && !i_flush;
        do_push  = i_push && !i_flush && ((count_q != 2'd2) || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (i_flush) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (do_push) wr_ptr_d = ~wr_ptr_q;
            if (do_pop)  rd_ptr_d = ~rd_ptr_q;
            count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    // Entry write: only the slot under the write pointer takes new data.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            pc_d[i]    = pc_q[i];
            instr_d[i] = instr_q[i];
            if (do_push && (wr_ptr_q == 1'(i))) begin
                pc_d[i]    = i_push_pc;
                instr_d[i] = i_push_instr;
            end
        end
    end

    // State registers; entries clear on reset so the head reads zero when empty.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                pc_q[i]    <= '0;
                instr_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            for (int i = 0; i < 2; i++) begin
                pc_q[i]    <= pc_d[i];
                instr_q[i] <= instr_d[i];
            end
        end
    end

    assign o_count      = count_q;
    assign o_head_pc    = pc_q[rd_ptr_q];
    assign o_head_instr = instr_q[rd_ptr_q];

endmodule

// File: rtl/instr_fetch_unit.sv
// Sequential fetch stage: waits for the loader's done flag, then streams
// instructions from a registered-read BRAM into decode through a 2-entry
// skid buffer, with branch redirect, HALT detection and PC wrap-around.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int                 ADDR_W     = ADDR_W_DEF,
    parameter int                 INSTR_W    = INSTR_W_DEF,
    parameter logic [ADDR_W-1:0]  START_ADDR = '0,
    parameter logic [INSTR_W-1:0] HALT_INSTR = INSTR_W'(HALT_INSTR_DEF)
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_load_done,
    output logic [ADDR_W-1:0]  o_addr_read,
    input  logic [INSTR_W-1:0] i_instr_read,
    input  logic               i_redirect_valid,
    input  logic [ADDR_W-1:0]  i_redirect_addr,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [INSTR_W-1:0] o_instr,
    output logic [ADDR_W-1:0]  o_pc,
    output logic               o_halted
);

    fetch_state_e       state_q, state_d;
    logic               sync1_q, sync1_d;
    logic               sync2_q, sync2_d;
    logic [ADDR_W-1:0]  fetch_ptr_q, fetch_ptr_d;
    logic               inflight_q, inflight_d;
    logic [ADDR_W-1:0]  tag_q, tag_d;
    logic               halted_q, halted_d;

    logic [1:0]         buf_count;
    logic               pop;
    logic               capture;
    logic               halt_seen;
    logic               redirect_take;
    logic               issue;
    logic               drain_empty;
    logic [1:0]         occ_after;

    // Handshake, capture and issue decisions for the current cycle.
    always_comb begin
        redirect_take = i_redirect_valid && ((state_q == ST_RUN) || (state_q == ST_DRAIN));
        pop           = (buf_count != 2'd0) && i_ready;
        capture       = inflight_q && (state_q == ST_RUN);
        halt_seen     = capture && (i_instr_read == HALT_INSTR);
        // Occupancy once this edge's capture and pop land; counting the pop
        // is what lets a held-high i_ready sustain one instruction per cycle.
        occ_after     = buf_count - {1'b0, pop} + {1'b0, inflight_q};
        // A HALT arriving now stops the next issue so nothing past it is fetched.
        issue         = (state_q == ST_RUN) && !redirect_take && !halt_seen && (occ_after < 2'd2);
        drain_empty   = (buf_count == 2'd0) || ((buf_count == 2'd1) && pop);
    end

    // Next-state logic for the FSM, fetch pointer and in-flight tracking.
    always_comb begin
        sync1_d     = i_load_done;
        sync2_d     = sync1_q;
        state_d     = state_q;
        fetch_ptr_d = issue ? fetch_ptr_q + 1'b1 : fetch_ptr_q;
        inflight_d  = issue;
        tag_d       = issue ? fetch_ptr_q : tag_q;
        halted_d    = halted_q;
        case (state_q)
            ST_IDLE: begin
                if (sync2_q) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (redirect_take) begin
                    fetch_ptr_d = i_redirect_addr;
                end else if (halt_seen) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (redirect_take) begin
                    fetch_ptr_d = i_redirect_addr;
                    state_d     = ST_RUN;
                end else if (drain_empty) begin
                    state_d  = ST_HALTED;
                    halted_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_HALTED;
            end
        endcase
    end

    // All control state, including the load-done synchronizer, in one register bank.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            fetch_ptr_q <= START_ADDR;
            inflight_q  <= 1'b0;
            tag_q       <= '0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            fetch_ptr_q <= fetch_ptr_d;
            inflight_q  <= inflight_d;
            tag_q       <= tag_d;
            halted_q    <= halted_d;
        end
    end

    fetch_skid_buf #(
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W)
    ) u_skid (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_push       (capture && !redirect_take),
        .i_push_pc    (tag_q),
        .i_push_instr (i_instr_read),
        .i_pop        (pop),
        .i_flush      (redirect_take),
        .o_count      (buf_count),
        .o_head_pc    (o_pc),
        .o_head_instr (o_instr)
    );

    assign o_addr_read = fetch_ptr_q;
    assign o_valid     = (buf_count != 2'd0);
    assign o_halted    = halted_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed testbench for instr_fetch_unit with a registered-read BRAM model.
module tb_instr_fetch_unit;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        i_rst;
    logic        i_load_done;
    logic [7:0]  o_addr_read;
    logic [15:0] i_instr_read;
    logic        i_redirect_valid;
    logic [7:0]  i_redirect_addr;
    logic        o_valid;
    logic        i_ready;
    logic [15:0] o_instr;
    logic [7:0]  o_pc;
    logic        o_halted;

    logic [15:0] mem [0:255];

    int errors = 0;
    int checks = 0;

    always #10 clk = ~clk;

    // BRAM: data for the sampled address appears the following cycle.
    always @(posedge clk) i_instr_read <= mem[o_addr_read];

    // One line per delivered instruction.
    always @(negedge clk)
        if (!i_rst && o_valid && i_ready)
            $display("xfer t=%0t pc=%02h instr=%04h", $time, o_pc, o_instr);

    instr_fetch_unit dut (
        .i_clk            (clk),
        .i_rst            (i_rst),
        .i_load_done      (i_load_done),
        .o_addr_read      (o_addr_read),
        .i_instr_read     (i_instr_read),
        .i_redirect_valid (i_redirect_valid),
        .i_redirect_addr  (i_redirect_addr),
        .o_valid          (o_valid),
        .i_ready          (i_ready),
        .o_instr          (o_instr),
        .o_pc             (o_pc),
        .o_halted         (o_halted)
    );

    task automatic fill_default;
        for (int i = 0; i < 256; i++) mem[i] = 16'hC000 | 16'(i);
    endtask

    task automatic do_reset;
        i_rst = 1'b1; i_load_done = 1'b0; i_ready = 1'b0;
        i_redirect_valid = 1'b0; i_redirect_addr = 8'h00;
        repeat (3) @(negedge clk);
        i_rst = 1'b0;
    endtask

    task automatic test_reset;
        fill_default();
        i_rst = 1'b1; i_load_done = 1'b0; i_ready = 1'b0;
        i_redirect_valid = 1'b0; i_redirect_addr = 8'h00;
        repeat (2) @(negedge clk);
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", o_valid); end
        checks++; if (o_addr_read !== 8'h00) begin errors++; $display("FAIL reset_addr got=%02h exp=00", o_addr_read); end
        checks++; if (o_instr !== 16'h0000) begin errors++; $display("FAIL reset_instr got=%04h exp=0000", o_instr); end
        checks++; if (o_pc !== 8'h00) begin errors++; $display("FAIL reset_pc got=%02h exp=00", o_pc); end
        checks++; if (o_halted !== 1'b0) begin errors++; $display("FAIL reset_halted got=%0b exp=0", o_halted); end
        i_rst = 1'b0;
    endtask

    task automatic test_stream_halt;
        logic [7:0]  pcs [4];
        logic [15:0] ins [4];
        int          cyc [4];
        logic [15:0] exp_ins [3];
        int nd, hcyc;
        logic [7:0] max_addr;
        nd = 0; hcyc = -1; max_addr = 8'h00;
        exp_ins = '{16'h1234, 16'h5678, 16'hF000};
        fill_default();
        mem[0] = 16'h1234; mem[1] = 16'h5678; mem[2] = 16'hF000;
        do_reset();
        i_ready = 1'b1; i_load_done = 1'b1;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (n == 3) i_load_done = 1'b0;
            if (o_addr_read > max_addr) max_addr = o_addr_read;
            if (o_valid) begin
                if (nd < 4) begin pcs[nd] = o_pc; ins[nd] = o_instr; cyc[nd] = n; end
                nd++;
            end
            if (o_halted && hcyc < 0) hcyc = n;
        end
        checks++; if (nd !== 3) begin errors++; $display("FAIL halt_count got=%0d exp=3", nd); end
        if (nd >= 3) begin
            for (int k = 0; k < 3; k++) begin
                checks++; if (pcs[k] !== 8'(k)) begin errors++; $display("FAIL halt_pc%0d got=%02h exp=%02h", k, pcs[k], k); end
                checks++; if (ins[k] !== exp_ins[k]) begin errors++; $display("FAIL halt_instr%0d got=%04h exp=%04h", k, ins[k], exp_ins[k]); end
            end
            checks++; if (cyc[2] - cyc[0] !== 2) begin errors++; $display("FAIL halt_rate span got=%0d exp=2", cyc[2] - cyc[0]); end
            checks++; if (hcyc !== cyc[2] + 1) begin errors++; $display("FAIL halted_timing got=%0d exp=%0d", hcyc, cyc[2] + 1); end
        end
        checks++; if (max_addr >= 8'h04) begin errors++; $display("FAIL halt_max_addr got=%02h exp<04", max_addr); end
    endtask

    task automatic test_backpressure;
        logic [7:0]  pcs [4];
        logic [15:0] ins [4];
        int          cyc [4];
        int w, bad, nd;
        w = 0; bad = 0; nd = 0;
        fill_default();
        do_reset();
        i_ready = 1'b0; i_load_done = 1'b1;
        while (!o_valid && w < 20) begin @(negedge clk); w++; end
        checks++; if (w !== 5) begin errors++; $display("FAIL bp_first_valid_latency got=%0d exp=5", w); end
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (!(o_valid === 1'b1 && o_pc === 8'h00)) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL bp_hold bad_cycles got=%0d exp=0", bad); end
        checks++; if (o_addr_read !== 8'h02) begin errors++; $display("FAIL bp_issues addr got=%02h exp=02", o_addr_read); end
        i_ready = 1'b1;
        for (int n = 0; n < 20 && nd < 4; n++) begin
            if (o_valid) begin pcs[nd] = o_pc; ins[nd] = o_instr; cyc[nd] = n; nd++; end
            @(negedge clk);
        end
        checks++; if (nd !== 4) begin errors++; $display("FAIL bp_count got=%0d exp=4", nd); end
        if (nd == 4) begin
            for (int k = 0; k < 4; k++) begin
                checks++; if (pcs[k] !== 8'(k) || ins[k] !== (16'hC000 | 16'(k))) begin
                    errors++; $display("FAIL bp_seq%0d got=%02h/%04h exp=%02h/%04h", k, pcs[k], ins[k], k, 16'hC000 | 16'(k));
                end
            end
            checks++; if (cyc[3] - cyc[0] !== 3) begin errors++; $display("FAIL bp_gap span got=%0d exp=3", cyc[3] - cyc[0]); end
        end
        i_load_done = 1'b0;
    endtask

    task automatic test_redirect;
        int w, seen5, bad67, got_first;
        logic [7:0]  first_pc;
        logic [15:0] first_ins;
        logic found;
        w = 0; seen5 = 0; bad67 = 0; got_first = 0; found = 1'b0;
        first_pc = 8'h00; first_ins = 16'h0000;
        fill_default();
        do_reset();
        i_ready = 1'b1; i_load_done = 1'b1;
        while (!found && w < 40) begin
            @(negedge clk); w++;
            if (o_valid && o_pc == 8'h05) found = 1'b1;
        end
        checks++; if (found !== 1'b1) begin errors++; $display("FAIL redir_reach_pc5 got=0 exp=1"); end
        seen5 = 1;
        i_redirect_valid = 1'b1; i_redirect_addr = 8'h40;
        @(negedge clk);
        i_redirect_valid = 1'b0;
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL redir_valid_low got=%0b exp=0", o_valid); end
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (o_valid) begin
                if (o_pc == 8'h05) seen5++;
                if (o_pc == 8'h06 || o_pc == 8'h07) bad67++;
                if (got_first == 0) begin first_pc = o_pc; first_ins = o_instr; got_first = 1; end
            end
        end
        checks++; if (seen5 !== 1) begin errors++; $display("FAIL redir_pc5_once got=%0d exp=1", seen5); end
        checks++; if (bad67 !== 0) begin errors++; $display("FAIL redir_pc67 got=%0d exp=0", bad67); end
        checks++; if (first_pc !== 8'h40 || first_ins !== 16'hC040) begin
            errors++; $display("FAIL redir_target got=%02h/%04h exp=40/C040", first_pc, first_ins);
        end
        i_load_done = 1'b0;
    endtask

    task automatic test_wrap;
        logic [7:0]  exp_pc [4];
        logic [7:0]  pcs [4];
        logic [15:0] ins [4];
        int w, nd;
        w = 0; nd = 0;
        exp_pc = '{8'hFE, 8'hFF, 8'h00, 8'h01};
        fill_default();
        do_reset();
        i_ready = 1'b1; i_load_done = 1'b1;
        while (!o_valid && w < 20) begin @(negedge clk); w++; end
        i_redirect_valid = 1'b1; i_redirect_addr = 8'hFE;
        @(negedge clk);
        i_redirect_valid = 1'b0;
        for (int n = 0; n < 20 && nd < 4; n++) begin
            @(negedge clk);
            if (o_valid) begin pcs[nd] = o_pc; ins[nd] = o_instr; nd++; end
        end
        checks++; if (nd !== 4) begin errors++; $display("FAIL wrap_count got=%0d exp=4", nd); end
        if (nd == 4) begin
            for (int k = 0; k < 4; k++) begin
                checks++; if (pcs[k] !== exp_pc[k] || ins[k] !== (16'hC000 | {8'h00, exp_pc[k]})) begin
                    errors++; $display("FAIL wrap_seq%0d got=%02h/%04h exp=%02h/%04h", k, pcs[k], ins[k], exp_pc[k], 16'hC000 | {8'h00, exp_pc[k]});
                end
            end
        end
        i_load_done = 1'b0;
    endtask

    task automatic test_halt_redirect;
        int w, halts, got_first, bad;
        logic found;
        logic [7:0] first_pc;
        w = 0; halts = 0; got_first = 0; bad = 0; found = 1'b0; first_pc = 8'h00;
        fill_default();
        mem[3] = 16'hF000;
        do_reset();
        i_ready = 1'b1; i_load_done = 1'b1;
        while (!found && w < 30) begin
            @(negedge clk); w++;
            if (i_instr_read == 16'hF000) found = 1'b1;
        end
        checks++; if (found !== 1'b1) begin errors++; $display("FAIL hr_reach_halt got=0 exp=1"); end
        i_redirect_valid = 1'b1; i_redirect_addr = 8'h10;
        @(negedge clk);
        i_redirect_valid = 1'b0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (o_valid) begin
                if (o_instr == 16'hF000 || o_pc == 8'h03) halts++;
                if (got_first == 0) begin first_pc = o_pc; got_first = 1; end
            end
        end
        checks++; if (halts !== 0) begin errors++; $display("FAIL hr_halt_delivered got=%0d exp=0", halts); end
        checks++; if (o_halted !== 1'b0) begin errors++; $display("FAIL hr_halted got=%0b exp=0", o_halted); end
        checks++; if (first_pc !== 8'h10) begin errors++; $display("FAIL hr_target got=%02h exp=10", first_pc); end

        // Redirect once HALTED must change nothing.
        fill_default();
        mem[1] = 16'hF000;
        do_reset();
        i_ready = 1'b1; i_load_done = 1'b1;
        w = 0;
        while (!o_halted && w < 30) begin @(negedge clk); w++; end
        checks++; if (o_halted !== 1'b1 || o_addr_read !== 8'h02) begin
            errors++; $display("FAIL hz_reach halted=%0b addr=%02h exp=1/02", o_halted, o_addr_read);
        end
        i_redirect_valid = 1'b1; i_redirect_addr = 8'h20;
        @(negedge clk);
        i_redirect_valid = 1'b0;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            if (o_valid !== 1'b0 || o_halted !== 1'b1 || o_addr_read !== 8'h02) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL hz_redirect_ignored bad_cycles got=%0d exp=0", bad); end
        i_load_done = 1'b0;
    endtask

    task automatic test_reset_mid;
        logic [7:0] pcs [3];
        int         cyc [3];
        int w, nd;
        w = 0; nd = 0;
        fill_default();
        do_reset();
        i_ready = 1'b0; i_load_done = 1'b1;
        while (!o_valid && w < 20) begin @(negedge clk); w++; end
        repeat (2) @(negedge clk);
        checks++; if (o_addr_read !== 8'h02) begin errors++; $display("FAIL rm_prefill addr got=%02h exp=02", o_addr_read); end
        i_rst = 1'b1;
        @(negedge clk);
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL rm_valid got=%0b exp=0", o_valid); end
        checks++; if (o_addr_read !== 8'h00) begin errors++; $display("FAIL rm_addr got=%02h exp=00", o_addr_read); end
        checks++; if (dut.state_q !== ST_IDLE) begin errors++; $display("FAIL rm_state got=%0d exp=0", dut.state_q); end
        i_rst = 1'b0;
        i_ready = 1'b1;
        for (int n = 1; n <= 20 && nd < 3; n++) begin
            @(negedge clk);
            if (o_valid) begin pcs[nd] = o_pc; cyc[nd] = n; nd++; end
        end
        checks++; if (nd !== 3) begin errors++; $display("FAIL rm_restart_count got=%0d exp=3", nd); end
        if (nd == 3) begin
            checks++; if (cyc[0] !== 5) begin errors++; $display("FAIL rm_restart_latency got=%0d exp=5", cyc[0]); end
            for (int k = 0; k < 3; k++) begin
                checks++; if (pcs[k] !== 8'(k)) begin errors++; $display("FAIL rm_seq%0d got=%02h exp=%02h", k, pcs[k], k); end
            end
        end
        i_load_done = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_stream_halt();
        test_backpressure();
        test_redirect();
        test_wrap();
        test_halt_redirect();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
